// File: rtl/vscale_pc_sel_ctrl_pkg.sv
// Shared select encodings, FSM states and request/response bundles for the next-PC controller.
// Select values follow the core's next-PC mux numbering.
package vscale_pc_sel_ctrl_pkg;

   localparam int PC_SRC_SEL_WIDTH = 3;

   typedef logic [PC_SRC_SEL_WIDTH-1:0] pc_sel_t;

   localparam pc_sel_t PC_BRANCH_TARGET = 3'd0;
   localparam pc_sel_t PC_PLUS_FOUR     = 3'd1;
   localparam pc_sel_t PC_JAL_TARGET    = 3'd2;
   localparam pc_sel_t PC_JALR_TARGET   = 3'd3;
   localparam pc_sel_t PC_REPLAY        = 3'd4;
   localparam pc_sel_t PC_HANDLER       = 3'd5;
   localparam pc_sel_t PC_EPC           = 3'd6;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic exception;
      logic eret;
      logic jalr;
      logic jal;
      logic branch_taken;
   } dx_req_t;

   typedef struct packed {
      pc_sel_t sel;
      logic    stall_if;
      logic    stall_dx;
      logic    kill_if;
      logic    kill_dx;
      logic    pending;
   } ctrl_out_t;

endpackage

// File: rtl/vscale_pc_sel_ctrl_prio.sv
// Redirect priority encoder: picks the single winning DX redirect source.
module vscale_redirect_prio
   import vscale_pc_sel_ctrl_pkg::*;
(
   input  logic    i_valid_dx,
   input  dx_req_t i_req,
   output logic    o_req_valid,
   output pc_sel_t o_req_sel
);

   always_comb begin
      o_req_valid = 1'b0;
      o_req_sel   = PC_PLUS_FOUR;
      if (i_valid_dx) begin
         o_req_valid = 1'b1;
         if (i_req.exception)         o_req_sel = PC_HANDLER;
         else if (i_req.eret)         o_req_sel = PC_EPC;
         else if (i_req.jalr)         o_req_sel = PC_JALR_TARGET;
         else if (i_req.jal)          o_req_sel = PC_JAL_TARGET;
         else if (i_req.branch_taken) o_req_sel = PC_BRANCH_TARGET;
         else                         o_req_valid = 1'b0;
      end
   end

endmodule

// File: rtl/vscale_pc_sel_ctrl.sv
// Next-PC sequencing: arbitrates DX redirects against imem back-pressure, holding a
// blocked redirect until the fetch is accepted, and flags over-long imem waits.
module vscale_pc_sel_ctrl
   import vscale_pc_sel_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 8
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    imem_wait,
   input  logic    valid_DX,
   input  logic    exception_DX,
   input  logic    eret_DX,
   input  logic    jal_DX,
   input  logic    jalr_DX,
   input  logic    branch_taken_DX,
   output pc_sel_t PC_src_sel,
   output logic    stall_IF,
   output logic    stall_DX,
   output logic    kill_IF,
   output logic    kill_DX,
   output logic    redirect_pending,
   output logic    imem_timeout
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   ctrl_state_t          r_state;
   pc_sel_t              r_held_sel;
   logic [CNT_WIDTH-1:0] r_wait_cnt;
   logic                 r_timeout;

   dx_req_t   w_req;
   logic      w_req_valid;
   pc_sel_t   w_req_sel;
   ctrl_out_t w_out;

   assign w_req = '{exception:    exception_DX,
                    eret:         eret_DX,
                    jalr:         jalr_DX,
                    jal:          jal_DX,
                    branch_taken: branch_taken_DX};

   vscale_redirect_prio u_prio (
      .i_valid_dx  (valid_DX),
      .i_req       (w_req),
      .o_req_valid (w_req_valid),
      .o_req_sel   (w_req_sel)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_held_sel <= PC_PLUS_FOUR;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_req_valid && imem_wait) begin
                  r_state    <= ST_HOLD;
                  r_held_sel <= w_req_sel;
               end
            end
            ST_HOLD: begin
               if (!imem_wait) r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase

         if (!imem_wait)                r_wait_cnt <= '0;
         else if (r_wait_cnt != '1)     r_wait_cnt <= r_wait_cnt + 1'b1;

         // Compare against the pre-increment count so the flag rises on the
         // edge that closes the TIMEOUT_CYCLES-th consecutive wait cycle.
         if (imem_wait && (r_wait_cnt == TIMEOUT_LAST)) r_timeout <= 1'b1;
      end
   end

   always_comb begin
      w_out = '{sel: PC_PLUS_FOUR, default: 1'b0};
      if (reset) begin
         w_out.kill_if = 1'b1;
         w_out.kill_dx = 1'b1;
      end else if (r_state == ST_HOLD) begin
         w_out.sel     = r_held_sel;
         w_out.pending = 1'b1;
         if (imem_wait) begin
            w_out.stall_if = 1'b1;
            w_out.stall_dx = 1'b1;
         end else begin
            w_out.kill_if = 1'b1;
            w_out.kill_dx = (r_held_sel == PC_HANDLER);
         end
      end else if (w_req_valid) begin
         w_out.sel = w_req_sel;
         if (imem_wait) begin
            w_out.stall_if = 1'b1;
            w_out.stall_dx = 1'b1;
         end else begin
            w_out.kill_if = 1'b1;
            w_out.kill_dx = exception_DX;
         end
      end else if (imem_wait) begin
         w_out.sel      = PC_REPLAY;
         w_out.stall_if = 1'b1;
         w_out.stall_dx = 1'b1;
      end
   end

   // A squashed register is never also held.
   assign PC_src_sel       = w_out.sel;
   assign kill_IF          = w_out.kill_if;
   assign kill_DX          = w_out.kill_dx;
   assign stall_IF         = w_out.stall_if & ~w_out.kill_if;
   assign stall_DX         = w_out.stall_dx & ~w_out.kill_dx;
   assign redirect_pending = w_out.pending;
   assign imem_timeout     = r_timeout;

endmodule

// File: tb/tb_vscale_pc_sel_ctrl.sv
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_vscale_pc_sel_ctrl;
   import vscale_pc_sel_ctrl_pkg::*;

   localparam int TOUT = 4;

   localparam logic [2:0] E_BR = 3'd0, E_P4 = 3'd1, E_JAL = 3'd2, E_JALR = 3'd3,
                          E_REPLAY = 3'd4, E_HND = 3'd5, E_EPC = 3'd6;

   logic clk = 1'b0;
   logic reset, imem_wait, valid_DX, exception_DX, eret_DX, jal_DX, jalr_DX, branch_taken_DX;
   pc_sel_t PC_src_sel;
   logic stall_IF, stall_DX, kill_IF, kill_DX, redirect_pending, imem_timeout;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: a pending redirect, its target, the run of waits and the flag.
   bit       m_pend;
   bit [2:0] m_held;
   int       m_waits;
   bit       m_to;

   vscale_pc_sel_ctrl #(.TIMEOUT_CYCLES(TOUT), .CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .imem_wait(imem_wait), .valid_DX(valid_DX),
      .exception_DX(exception_DX), .eret_DX(eret_DX), .jal_DX(jal_DX), .jalr_DX(jalr_DX),
      .branch_taken_DX(branch_taken_DX), .PC_src_sel(PC_src_sel), .stall_IF(stall_IF),
      .stall_DX(stall_DX), .kill_IF(kill_IF), .kill_DX(kill_DX),
      .redirect_pending(redirect_pending), .imem_timeout(imem_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] mk(input logic [2:0] sel, input logic sif, sdx, kif, kdx, rp, to);
      return {sel, sif, sdx, kif, kdx, rp, to};
   endfunction

   function automatic logic [8:0] obs();
      return {PC_src_sel, stall_IF, stall_DX, kill_IF, kill_DX, redirect_pending, imem_timeout};
   endfunction

   task automatic drive(input bit rst, w, v, exc, er, jl, jr, br);
      reset = rst; imem_wait = w; valid_DX = v; exception_DX = exc;
      eret_DX = er; jal_DX = jl; jalr_DX = jr; branch_taken_DX = br;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Winning redirect from the DX request lines; -1 when nothing is requested.
   function automatic int want_req();
      if (!valid_DX)       return -1;
      if (exception_DX)    return E_HND;
      if (eret_DX)         return E_EPC;
      if (jalr_DX)         return E_JALR;
      if (jal_DX)          return E_JAL;
      if (branch_taken_DX) return E_BR;
      return -1;
   endfunction

   function automatic logic [8:0] model_out();
      int r = want_req();
      if (reset)      return mk(E_P4, 0, 0, 1, 1, 0, m_to);
      if (m_pend)     return imem_wait ? mk(m_held, 1, 1, 0, 0, 1, m_to)
                                       : mk(m_held, 0, 0, 1, m_held == E_HND, 1, m_to);
      if (r >= 0)     return imem_wait ? mk(3'(r), 1, 1, 0, 0, 0, m_to)
                                       : mk(3'(r), 0, 0, 1, exception_DX, 0, m_to);
      return imem_wait ? mk(E_REPLAY, 1, 1, 0, 0, 0, m_to) : mk(E_P4, 0, 0, 0, 0, 0, m_to);
   endfunction

   task automatic model_step();
      int r = want_req();
      if (reset) begin
         m_pend = 0; m_waits = 0; m_to = 0;
      end else begin
         m_waits = imem_wait ? m_waits + 1 : 0;
         if (m_waits >= TOUT) m_to = 1;
         if (m_pend) begin
            if (!imem_wait) m_pend = 0;
         end else if (r >= 0 && imem_wait) begin
            m_pend = 1; m_held = 3'(r);
         end
      end
   endtask

   task automatic test_reset();
      logic [8:0] e;
      drive(1, 1, 1, 0, 0, 1, 0, 0); tick();
      drive(1, 1, 1, 0, 0, 1, 0, 0);
      e = mk(E_P4, 0, 0, 1, 1, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL reset_outputs got=%b exp=%b", obs(), e); end
      tick();
   endtask

   task automatic test_jal();
      logic [8:0] e;
      drive(0, 0, 1, 0, 0, 1, 0, 0);
      e = mk(E_JAL, 0, 0, 1, 0, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL jal_nowait got=%b exp=%b", obs(), e); end
      tick();
   endtask

   task automatic test_exc_hold();
      logic [8:0] e;
      for (int c = 1; c <= 4; c++) begin
         drive(0, c < 4, 1, 1, 0, 0, 0, 1);
         if (c == 1)     e = mk(E_HND, 1, 1, 0, 0, 0, 0);
         else if (c < 4) e = mk(E_HND, 1, 1, 0, 0, 1, 0);
         else            e = mk(E_HND, 0, 0, 1, 1, 1, 0);
         vectors++;
         if (obs() !== e) begin miscompares++; $display("FAIL exc_hold_c%0d got=%b exp=%b", c, obs(), e); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      e = mk(E_P4, 0, 0, 0, 0, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL exc_release_run got=%b exp=%b", obs(), e); end
      tick();
   endtask

   task automatic test_hold_ignores_dx();
      logic [8:0] e;
      drive(0, 1, 1, 0, 1, 0, 0, 0);
      e = mk(E_EPC, 1, 1, 0, 0, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL eret_block got=%b exp=%b", obs(), e); end
      tick();
      drive(0, 1, 1, 0, 0, 0, 1, 0);
      e = mk(E_EPC, 1, 1, 0, 0, 1, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL hold_jalr_wait got=%b exp=%b", obs(), e); end
      tick();
      drive(0, 0, 1, 0, 0, 0, 1, 0);
      e = mk(E_EPC, 0, 0, 1, 0, 1, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL hold_jalr_release got=%b exp=%b", obs(), e); end
      tick();
      drive(0, 0, 1, 0, 0, 0, 1, 0);
      e = mk(E_JALR, 0, 0, 1, 0, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL jalr_after_hold got=%b exp=%b", obs(), e); end
      tick();
   endtask

   task automatic test_replay();
      logic [8:0] e;
      for (int c = 0; c < 2; c++) begin
         drive(0, 1, 0, 0, 0, 1, 0, 0);
         e = mk(E_REPLAY, 1, 1, 0, 0, 0, 0); vectors++;
         if (obs() !== e) begin miscompares++; $display("FAIL replay_c%0d got=%b exp=%b", c, obs(), e); end
         tick();
      end
      drive(0, 0, 1, 0, 0, 0, 0, 0);
      e = mk(E_P4, 0, 0, 0, 0, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL replay_done got=%b exp=%b", obs(), e); end
      tick();
   endtask

   task automatic test_timeout();
      logic [8:0] e;
      // Three waits, a gap, three more: the run restarts, so no timeout.
      for (int c = 0; c < 7; c++) begin
         drive(0, c != 3, 0, 0, 0, 0, 0, 0); tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (imem_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_run_restart got=%b exp=0", imem_timeout); end
      tick();
      for (int c = 1; c <= TOUT + 1; c++) begin
         drive(0, 1, 0, 0, 0, 0, 0, 0);
         vectors++;
         if (imem_timeout !== (c > TOUT)) begin
            miscompares++; $display("FAIL timeout_c%0d got=%b exp=%b", c, imem_timeout, c > TOUT);
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      e = mk(E_P4, 0, 0, 0, 0, 0, 1); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL timeout_sticky got=%b exp=%b", obs(), e); end
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      e = mk(E_P4, 0, 0, 1, 1, 0, 1); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL timeout_reset_cycle got=%b exp=%b", obs(), e); end
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (imem_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_cleared got=%b exp=0", imem_timeout); end
      tick();
   endtask

   task automatic test_reset_in_hold();
      logic [8:0] e;
      drive(0, 1, 1, 0, 0, 1, 0, 0); tick();
      drive(1, 1, 1, 0, 0, 1, 0, 0);
      e = mk(E_P4, 0, 0, 1, 1, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL reset_in_hold got=%b exp=%b", obs(), e); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      e = mk(E_P4, 0, 0, 0, 0, 0, 0); vectors++;
      if (obs() !== e) begin miscompares++; $display("FAIL after_reset_hold got=%b exp=%b", obs(), e); end
      tick();
   endtask

   task automatic test_random();
      logic [8:0] e;
      m_pend = 0; m_held = E_P4; m_waits = 0; m_to = 0;
      drive(1, 0, 0, 0, 0, 0, 0, 0); model_step(); tick();
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
         e = model_out(); vectors++;
         if (obs() !== e) begin miscompares++; $display("FAIL random_n%0d got=%b exp=%b", n, obs(), e); end
         model_step();
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_jal();
      test_exc_hold();
      test_hold_ignores_dx();
      test_replay();
      test_timeout();
      test_reset_in_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
